memory_writeback_pipe: RTL and testbench

- W-stage pipeline register plus writeback driver.
- Captures Memory-stage results and drives the register-file write ports W_dstE/W_valE/W_dstM/W_valM, which the decode stage consumes.
- Owns the processor status state machine (run/halt/error) and freezes writeback once a halting or faulting instruction retires.
- Sits between the memory stage and the decode/writeback register file.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/wb_status_fsm.sv | 57 +++++
 rtl/memory_writeback_pipe.sv | 143 ++++++++++++++
 tb/tb_memory_writeback_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the writeback slice of the Y86-64 pipeline.
//   - icode values, register IDs, status codes
//   - writeback status FSM encoding
//   - bubble (NOP) contents of the W pipeline register
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Processor status FSM
  typedef enum logic [1:0] {
    FSM_RUN  = 2'd0,
    FSM_HALT = 2'd1,
    FSM_ERR  = 2'd2
  } wb_state_e;

  // Control fields of the W register
  typedef struct packed {
    logic [3:0] icode;
    logic [2:0] stat;
  } w_ctrl_t;

  // Bubble contents (also the reset contents)
  localparam w_ctrl_t W_CTRL_BUBBLE = '{icode: INOP, stat: SAOK};

  // Status codes that stop the processor
  function automatic logic is_fault_stat(input logic [2:0] s);
    return (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/wb_status_fsm.sv
// wb_status_fsm: processor status state machine (RUN / HALT / ERR).
//   clk_i, rst_i : clock, synchronous active-high reset
//   W_stat_i     : status of the instruction currently in W
//   state_o      : current FSM state
//   stat_o       : processor status (AOK while running, else latched W status)
//   halted_o     : processor stopped (HALT or ERR)
//   freeze_o     : W register must hold (stopped, or non-AOK instruction in W)
module wb_status_fsm
  import y86_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] W_stat_i,
  output wb_state_e  state_o,
  output logic [2:0] stat_o,
  output logic       halted_o,
  output logic       freeze_o
);

  wb_state_e  state_q, state_d;
  logic [2:0] stat_q, stat_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FSM_RUN;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  // HALT and ERR are terminal; only reset leaves them. Unknown status codes
  // keep the FSM in RUN (W still freezes on them, see freeze_o).
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    case (state_q)
      FSM_RUN: begin
        if (W_stat_i == SHLT) begin
          state_d = FSM_HALT;
          stat_d  = W_stat_i;
        end else if (is_fault_stat(W_stat_i)) begin
          state_d = FSM_ERR;
          stat_d  = W_stat_i;
        end
      end
      default: ;
    endcase
  end

  assign state_o  = state_q;
  assign halted_o = (state_q != FSM_RUN);
  assign stat_o   = halted_o ? stat_q : SAOK;
  assign freeze_o = halted_o || (W_stat_i != SAOK);

endmodule

// File: rtl/memory_writeback_pipe.sv
// memory_writeback_pipe: W pipeline register and register-file write driver.
//   Captures M-stage results, drives W_dstE/W_valE/W_dstM/W_valM to the
//   register file, and freezes once a halting/faulting instruction reaches W.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   W_stall_i, W_bubble_i     : pipeline control (stall wins over bubble)
//   M_icode_i, m_stat_i, M_dstE_i, M_valE_i, M_dstM_i, m_valM_i : M inputs
//   W_icode_o, W_stat_o       : registered icode / status
//   W_dstE_o, W_valE_o        : regfile E write port (RNONE = no write)
//   W_dstM_o, W_valM_o        : regfile M write port (RNONE = no write)
//   stat_o, halted_o          : processor status
//   retired_o                 : retired-instruction count (WB_RETIRE_CNT_EN only)
// Optional feature macro: WB_RETIRE_CNT_EN
module memory_writeback_pipe
  import y86_pkg::*;
#(
  parameter int DW = 64,
  parameter int RW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          W_stall_i,
  input  logic          W_bubble_i,
  input  logic [3:0]    M_icode_i,
  input  logic [2:0]    m_stat_i,
  input  logic [RW-1:0] M_dstE_i,
  input  logic [DW-1:0] M_valE_i,
  input  logic [RW-1:0] M_dstM_i,
  input  logic [DW-1:0] m_valM_i,
  output logic [3:0]    W_icode_o,
  output logic [2:0]    W_stat_o,
  output logic [RW-1:0] W_dstE_o,
  output logic [DW-1:0] W_valE_o,
  output logic [RW-1:0] W_dstM_o,
  output logic [DW-1:0] W_valM_o,
  output logic [2:0]    stat_o,
  output logic          halted_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]   retired_o
`endif
);

  localparam logic [RW-1:0] REG_NONE = {RW{1'b1}};

  w_ctrl_t       ctrl_q, ctrl_d;
  logic [RW-1:0] dstE_q, dstE_d, dstM_q, dstM_d;
  logic [DW-1:0] valE_q, valE_d, valM_q, valM_d;

  wb_state_e     state;
  logic          freeze;

  wb_status_fsm u_fsm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .W_stat_i(ctrl_q.stat),
    .state_o (state),
    .stat_o  (stat_o),
    .halted_o(halted_o),
    .freeze_o(freeze)
  );

  // W register next state: freeze > stall > bubble > load
  always_comb begin
    ctrl_d = ctrl_q;
    dstE_d = dstE_q;
    valE_d = valE_q;
    dstM_d = dstM_q;
    valM_d = valM_q;
    if (freeze || W_stall_i) begin
      // hold
    end else if (W_bubble_i) begin
      ctrl_d = W_CTRL_BUBBLE;
      dstE_d = REG_NONE;
      valE_d = '0;
      dstM_d = REG_NONE;
      valM_d = '0;
    end else begin
      ctrl_d = '{icode: M_icode_i, stat: m_stat_i};
      dstE_d = M_dstE_i;
      valE_d = M_valE_i;
      dstM_d = M_dstM_i;
      valM_d = m_valM_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= W_CTRL_BUBBLE;
      dstE_q <= REG_NONE;
      valE_q <= '0;
      dstM_q <= REG_NONE;
      valM_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dstE_q <= dstE_d;
      valE_q <= valE_d;
      dstM_q <= dstM_d;
      valM_q <= valM_d;
    end
  end

  // Write suppression. A non-AOK or post-halt instruction never writes.
  // When both ports target the same register (popq %rsp) the M write wins.
  logic wr_block;
  assign wr_block = (ctrl_q.stat != SAOK) || (state != FSM_RUN);

  always_comb begin
    W_dstE_o = dstE_q;
    W_dstM_o = dstM_q;
    if (wr_block) begin
      W_dstE_o = REG_NONE;
      W_dstM_o = REG_NONE;
    end else if ((dstE_q == dstM_q) && (dstM_q != REG_NONE)) begin
      W_dstE_o = REG_NONE;
    end
  end

  assign W_icode_o = ctrl_q.icode;
  assign W_stat_o  = ctrl_q.stat;
  assign W_valE_o  = valE_q;
  assign W_valM_o  = valM_q;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the edge it leaves W; stalled edges keep it in
  // W so it is counted exactly once. !freeze already implies W status AOK.
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (!freeze && !W_stall_i && (ctrl_q.icode != INOP))
      retired_d = retired_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_memory_writeback_pipe.sv
module tb_memory_writeback_pipe;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, bubble;
  logic [3:0]  m_icode;
  logic [2:0]  m_stat;
  logic [3:0]  m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  w_icode, w_dstE, w_dstM;
  logic [2:0]  w_stat, p_stat;
  logic [63:0] w_valE, w_valM;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_writeback_pipe dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .W_stall_i (stall),
    .W_bubble_i(bubble),
    .M_icode_i (m_icode),
    .m_stat_i  (m_stat),
    .M_dstE_i  (m_dstE),
    .M_valE_i  (m_valE),
    .M_dstM_i  (m_dstM),
    .m_valM_i  (m_valM),
    .W_icode_o (w_icode),
    .W_stat_o  (w_stat),
    .W_dstE_o  (w_dstE),
    .W_valE_o  (w_valE),
    .W_dstM_o  (w_dstM),
    .W_valM_o  (w_valM),
    .stat_o    (p_stat),
    .halted_o  (halted)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_o (retired)
`endif
  );

  // Reference model: the instruction sitting in W, whether the processor has
  // stopped (and with which status), and how many instructions have left W.
  logic [3:0]  r_icode, r_dstE, r_dstM;
  logic [2:0]  r_stat, r_stop_stat;
  logic [63:0] r_valE, r_valM, r_retired;
  bit          r_stopped;

  task automatic model_edge();
    bit stuck;
    if (rst) begin
      r_icode = INOP; r_stat = SAOK; r_dstE = 4'hF; r_dstM = 4'hF;
      r_valE = 0; r_valM = 0; r_stopped = 0; r_stop_stat = SAOK; r_retired = 0;
      return;
    end
    stuck = r_stopped || (r_stat != SAOK);
    if (!stuck && !stall && r_icode != INOP) r_retired++;
    if (!r_stopped && (r_stat == SHLT || r_stat == SADR || r_stat == SINS)) begin
      r_stopped = 1; r_stop_stat = r_stat;
    end
    if (stuck || stall) return;
    if (bubble) begin
      r_icode = INOP; r_stat = SAOK; r_dstE = 4'hF; r_dstM = 4'hF;
      r_valE = 0; r_valM = 0;
    end else begin
      r_icode = m_icode; r_stat = m_stat; r_dstE = m_dstE; r_dstM = m_dstM;
      r_valE = m_valE; r_valM = m_valM;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit writes_ok;
    logic [3:0] e_dstE, e_dstM;
    writes_ok = !r_stopped && (r_stat == SAOK);
    e_dstM = writes_ok ? r_dstM : 4'hF;
    e_dstE = (!writes_ok || (r_dstE == r_dstM && r_dstM != 4'hF)) ? 4'hF : r_dstE;
    check({tag, ".icode"}, 64'(w_icode), 64'(r_icode));
    check({tag, ".wstat"}, 64'(w_stat), 64'(r_stat));
    check({tag, ".dstE"}, 64'(w_dstE), 64'(e_dstE));
    check({tag, ".valE"}, w_valE, r_valE);
    check({tag, ".dstM"}, 64'(w_dstM), 64'(e_dstM));
    check({tag, ".valM"}, w_valM, r_valM);
    check({tag, ".stat"}, 64'(p_stat), 64'(r_stopped ? r_stop_stat : SAOK));
    check({tag, ".halted"}, 64'(halted), 64'(r_stopped));
`ifdef WB_RETIRE_CNT_EN
    check({tag, ".retired"}, retired, r_retired);
`endif
  endtask

  // One clock edge: model follows the inputs present at the edge, outputs
  // are compared 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_m(input logic [3:0] ic, input logic [2:0] st,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    m_icode = ic; m_stat = st; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
  endtask

  initial begin
    rst = 1; stall = 0; bubble = 0;
    drive_m(IOPQ, SAOK, 4'h7, 64'hDEAD, 4'h8, 64'hBEEF);

    // Reset contents
    step("reset");
    check("reset.dstE", 64'(w_dstE), 64'hF);
    check("reset.icode", 64'(w_icode), 64'(INOP));

    // 1: basic load
    rst = 0;
    drive_m(IOPQ, SAOK, 4'h3, 64'h55, 4'hF, 64'h0);
    step("t1");
    check("t1.dstE", 64'(w_dstE), 64'h3);
    check("t1.valE", w_valE, 64'h55);

    // 2: stall beats bubble, then bubble alone
    drive_m(IMRMOVQ, SAOK, 4'hF, 64'h0, 4'h5, 64'h1234);
    step("t2.load");
    stall = 1; bubble = 1;
    drive_m(IOPQ, SAOK, 4'h1, 64'h99, 4'h2, 64'h77);
    step("t2.stall");
    check("t2.stall.valM", w_valM, 64'h1234);
    stall = 0;
    step("t2.bubble");
    check("t2.bubble.icode", 64'(w_icode), 64'(INOP));
    check("t2.bubble.dstM", 64'(w_dstM), 64'hF);
    bubble = 0;

    // 3: popq %rsp, M write wins
    drive_m(IPOPQ, SAOK, RRSP, 64'h100, RRSP, 64'h200);
    step("t3");
    check("t3.dstE", 64'(w_dstE), 64'hF);
    check("t3.dstM", 64'(w_dstM), 64'h4);
    check("t3.valM", w_valM, 64'h200);

    // 4: halt freezes W
    drive_m(IHALT, SHLT, 4'h1, 64'h11, 4'h2, 64'h22);
    step("t4.hlt");
    check("t4.hlt.halted", 64'(halted), 64'h0);
    check("t4.hlt.dstE", 64'(w_dstE), 64'hF);
    drive_m(IOPQ, SAOK, 4'h3, 64'h33, 4'hF, 64'h0);
    step("t4.after1");
    check("t4.halted", 64'(halted), 64'h1);
    check("t4.stat", 64'(p_stat), 64'(SHLT));
    stall = 1; bubble = 1;
    step("t4.after2");
    stall = 0;
    step("t4.after3");
    check("t4.frozen.icode", 64'(w_icode), 64'(IHALT));
    bubble = 0;

    // 5: address fault, then reset recovery
    rst = 1;
    step("t5.rst");
    rst = 0;
    drive_m(IMRMOVQ, SADR, 4'h2, 64'h44, 4'h6, 64'h66);
    step("t5.adr");
    check("t5.adr.dstE", 64'(w_dstE), 64'hF);
    drive_m(IOPQ, SAOK, 4'h3, 64'h33, 4'hF, 64'h0);
    step("t5.err");
    check("t5.stat", 64'(p_stat), 64'(SADR));
    check("t5.halted", 64'(halted), 64'h1);
    rst = 1;
    step("t5.rst2");
    check("t5.rst2.halted", 64'(halted), 64'h0);
    rst = 0;
    step("t5.resume");
    check("t5.resume.dstE", 64'(w_dstE), 64'h3);

    // 6: retire count over loads, bubble, stall, then halt
    rst = 1;
    step("t6.rst");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      drive_m(IOPQ, SAOK, 4'(i), 64'(i), 4'hF, 64'h0);
      step("t6.load");
    end
    bubble = 1;
    step("t6.bubble");
    bubble = 0; stall = 1;
    step("t6.stall");
    stall = 0;
    drive_m(IHALT, SHLT, 4'hF, 64'h0, 4'hF, 64'h0);
    step("t6.hlt");
    drive_m(IOPQ, SAOK, 4'h1, 64'h1, 4'hF, 64'h0);
    for (int i = 0; i < 3; i++) step("t6.held");
`ifdef WB_RETIRE_CNT_EN
    check("t6.retired", retired, 64'd3);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0] de;
      rst    = ($urandom_range(0, 29) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      bubble = ($urandom_range(0, 5) == 0);
      de     = 4'($urandom_range(0, 15));
      drive_m(4'($urandom_range(0, 11)),
              ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : SAOK,
              de, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15)),
              {$urandom, $urandom});
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
